// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and widths for the automatic clock-gating controller.
package clk_gate_ctrl_pkg;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned STAT_CNT_W = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_ON   = 3'd0,
        ST_IDLE = 3'd1,
        ST_REQ  = 3'd2,
        ST_OFF  = 3'd3,
        ST_WAKE = 3'd4
    } state_e;

endpackage

// File: rtl/clk_gate_ctrl_icg.sv
// Controller plus behavioural latch-based clock gate, exposing the gated clock.
// Passes through the CLK_GATE_CTRL_STAT_EN statistics ports when enabled.
module clk_icg (
    input  logic clk_i,
    input  logic en_i,
    input  logic te_i,
    output logic gclk_o
);

    logic en_l;

    // Transparent while the clock is low so the enable is stable across the high phase.
    always_latch begin
        if (!clk_i) begin
            en_l <= en_i | te_i;
        end
    end

    assign gclk_o = clk_i & en_l;

endmodule

module clk_gate_ctrl_icg
    import clk_gate_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned WAKE_HOLD = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  busy_i,
    input  logic                  wake_i,
    input  logic                  force_on_i,
    input  logic [CNT_WIDTH-1:0]  idle_thr_i,
    output logic                  slp_req_o,
    input  logic                  slp_ack_i,
    input  logic                  scan_en_i,
    output logic                  en_o,
    output logic                  gated_o,
`ifdef CLK_GATE_CTRL_STAT_EN
    output logic [STAT_CNT_W-1:0] gate_cnt_o,
    output logic                  gate_evt_o,
`endif
    output logic [STATE_W-1:0]    state_o,
    output logic                  gclk_o
);

    clk_gate_ctrl #(
        .CNT_WIDTH (CNT_WIDTH),
        .WAKE_HOLD (WAKE_HOLD)
    ) u_ctrl (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .busy_i     (busy_i),
        .wake_i     (wake_i),
        .force_on_i (force_on_i),
        .idle_thr_i (idle_thr_i),
        .slp_req_o  (slp_req_o),
        .slp_ack_i  (slp_ack_i),
        .en_o       (en_o),
        .gated_o    (gated_o),
`ifdef CLK_GATE_CTRL_STAT_EN
        .gate_cnt_o (gate_cnt_o),
        .gate_evt_o (gate_evt_o),
`endif
        .state_o    (state_o)
    );

    clk_icg u_icg (
        .clk_i  (clk_i),
        .en_i   (en_o),
        .te_i   (scan_en_i),
        .gclk_o (gclk_o)
    );

endmodule

// File: rtl/clk_gate_ctrl.sv
// Idle-driven clock-gate enable controller with a four-phase sleep handshake.
// Optional gating statistics (gate_cnt_o, gate_evt_o) under CLK_GATE_CTRL_STAT_EN.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned WAKE_HOLD = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  busy_i,
    input  logic                  wake_i,
    input  logic                  force_on_i,
    input  logic [CNT_WIDTH-1:0]  idle_thr_i,
    output logic                  slp_req_o,
    input  logic                  slp_ack_i,
    output logic                  en_o,
    output logic                  gated_o,
`ifdef CLK_GATE_CTRL_STAT_EN
    output logic [STAT_CNT_W-1:0] gate_cnt_o,
    output logic                  gate_evt_o,
`endif
    output logic [STATE_W-1:0]    state_o
);

    localparam int unsigned HOLD_W = $clog2(WAKE_HOLD + 2);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 en_q, en_d;
    logic                 req_q, req_d;
    logic                 gated_q, gated_d;
    logic                 wake_c;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_ON;
            cnt_q   <= '0;
            hold_q  <= '0;
            en_q    <= 1'b1;
            req_q   <= 1'b0;
            gated_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            en_q    <= en_d;
            req_q   <= req_d;
            gated_q <= gated_d;
        end
    end

    // Next state; outputs are decoded from the next state so they register with it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = '0;
        wake_c  = wake_i | busy_i | force_on_i;

        case (state_q)
            ST_ON: begin
                cnt_d = '0;
                if (!wake_c && (idle_thr_i != '0)) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                if (wake_c || (idle_thr_i == '0)) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end else if (cnt_q >= idle_thr_i) begin
                    state_d = ST_REQ;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_REQ: begin
                if (wake_c) begin
                    state_d = ST_WAKE;
                end else if (slp_ack_i) begin
                    state_d = ST_OFF;
                end
            end
            ST_OFF: begin
                if (wake_c) begin
                    state_d = ST_WAKE;
                end
            end
            ST_WAKE: begin
                // Leave only after req has been seen low and ack has followed it.
                if (!req_q && !slp_ack_i) begin
                    state_d = ST_ON;
                end
            end
            default: begin
                state_d = ST_ON;
                cnt_d   = '0;
            end
        endcase

        if (state_d == ST_WAKE) begin
            if (state_q != ST_WAKE) begin
                hold_d = HOLD_W'(1);
            end else if (hold_q == HOLD_W'(WAKE_HOLD + 1)) begin
                hold_d = hold_q;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end

        en_d    = (state_d != ST_OFF);
        gated_d = (state_d == ST_OFF);
        req_d   = (state_d == ST_REQ) || (state_d == ST_OFF) ||
                  ((state_d == ST_WAKE) && (hold_d <= HOLD_W'(WAKE_HOLD)));
    end

    assign en_o      = en_q;
    assign slp_req_o = req_q;
    assign gated_o   = gated_q;
    assign state_o   = state_q;

`ifdef CLK_GATE_CTRL_STAT_EN
    logic [STAT_CNT_W-1:0] gate_cnt_q, gate_cnt_d;
    logic                  gate_evt_q, gate_evt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gate_cnt_q <= '0;
            gate_evt_q <= 1'b0;
        end else begin
            gate_cnt_q <= gate_cnt_d;
            gate_evt_q <= gate_evt_d;
        end
    end

    // Saturating count of cycles spent gated, plus an entry pulse.
    always_comb begin
        gate_cnt_d = gate_cnt_q;
        if ((state_q == ST_OFF) && (gate_cnt_q != '1)) begin
            gate_cnt_d = gate_cnt_q + STAT_CNT_W'(1);
        end
        gate_evt_d = (state_d == ST_OFF) && (state_q != ST_OFF);
    end

    assign gate_cnt_o = gate_cnt_q;
    assign gate_evt_o = gate_evt_q;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: vector table plus handshake corner sequences.
module tb_clk_gate_ctrl;

    localparam logic [2:0] S_ON = 3'd0, S_IDLE = 3'd1, S_REQ = 3'd2, S_OFF = 3'd3, S_WAKE = 3'd4;

    logic       clk = 1'b0;
    logic       rst, busy, wake, frc, ack;
    logic [7:0] thr;
    logic       req, en, gated;
    logic [2:0] st;
    logic       w_req, w_en, w_gated, gclk;
    logic [2:0] w_st;
`ifdef CLK_GATE_CTRL_STAT_EN
    logic [31:0] gate_cnt, w_gate_cnt;
    logic        gate_evt, w_gate_evt;
    int          evt_cnt = 0;
`endif

    int n_pass = 0;
    int n_tot  = 0;
    int gclk_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge gclk) gclk_cnt++;

    clk_gate_ctrl dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .busy_i     (busy),
        .wake_i     (wake),
        .force_on_i (frc),
        .idle_thr_i (thr),
        .slp_req_o  (req),
        .slp_ack_i  (ack),
        .en_o       (en),
        .gated_o    (gated),
`ifdef CLK_GATE_CTRL_STAT_EN
        .gate_cnt_o (gate_cnt),
        .gate_evt_o (gate_evt),
`endif
        .state_o    (st)
    );

    clk_gate_ctrl_icg u_wrap (
        .clk_i      (clk),
        .rst_i      (rst),
        .busy_i     (busy),
        .wake_i     (wake),
        .force_on_i (frc),
        .idle_thr_i (thr),
        .slp_req_o  (w_req),
        .slp_ack_i  (ack),
        .scan_en_i  (1'b0),
        .en_o       (w_en),
        .gated_o    (w_gated),
`ifdef CLK_GATE_CTRL_STAT_EN
        .gate_cnt_o (w_gate_cnt),
        .gate_evt_o (w_gate_evt),
`endif
        .state_o    (w_st),
        .gclk_o     (gclk)
    );

`ifdef CLK_GATE_CTRL_STAT_EN
    always @(posedge clk) if (gate_evt === 1'b1) evt_cnt++;
`endif

    typedef struct {
        logic       rst, busy, wake, frc, ack;
        logic [7:0] thr;
        logic [2:0] st;
        logic       en, req, gated;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic r, input logic b, input logic w, input logic f,
                                input logic a, input logic [7:0] t, input logic [2:0] s,
                                input logic e, input logic q, input logic g);
        vec_t v;
        v.rst = r; v.busy = b; v.wake = w; v.frc = f; v.ack = a; v.thr = t;
        v.st = s; v.en = e; v.req = q; v.gated = g;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    task automatic drive(input logic r, input logic b, input logic w, input logic f,
                         input logic a, input logic [7:0] t);
        rst = r; busy = b; wake = w; frc = f; ack = a; thr = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [2:0] s, input logic e,
                              input logic q, input logic g);
        chk({nm, ".state"}, 32'(st), 32'(s));
        chk({nm, ".en"}, 32'(en), 32'(e));
        chk({nm, ".req"}, 32'(req), 32'(q));
        chk({nm, ".gated"}, 32'(gated), 32'(g));
    endtask

    // Reset, then idle with threshold 4 until the first REQ cycle.
    task automatic reach_req(input string nm);
        drive(1, 0, 0, 0, 0, 8'd4);
        tick();
        drive(0, 0, 0, 0, 0, 8'd4);
        repeat (5) tick();
        expect_out({nm, ".in_req"}, S_REQ, 1, 1, 0);
    endtask

    initial begin
        int g0;
        drive(1, 0, 0, 0, 0, 8'd0);
        repeat (2) tick();
        expect_out("reset", S_ON, 1, 0, 0);
`ifdef CLK_GATE_CTRL_STAT_EN
        chk("reset.gate_cnt", gate_cnt, 32'd0);
`endif

        // Threshold gating, wake from OFF, spurious ack in ON/IDLE.
        vecs[0]  = mk(1, 0, 0, 0, 0, 8'd4, S_ON,   1, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 8'd4, S_IDLE, 1, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 8'd4, S_IDLE, 1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 8'd4, S_IDLE, 1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 8'd4, S_IDLE, 1, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 8'd4, S_REQ,  1, 1, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 8'd4, S_REQ,  1, 1, 0);
        vecs[7]  = mk(0, 0, 0, 0, 1, 8'd4, S_OFF,  0, 1, 1);
        vecs[8]  = mk(0, 0, 0, 0, 1, 8'd4, S_OFF,  0, 1, 1);
        vecs[9]  = mk(0, 0, 1, 0, 1, 8'd4, S_WAKE, 1, 1, 0);
        vecs[10] = mk(0, 0, 0, 0, 1, 8'd4, S_WAKE, 1, 1, 0);
        vecs[11] = mk(0, 0, 0, 0, 1, 8'd4, S_WAKE, 1, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 8'd4, S_ON,   1, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 1, 8'd4, S_IDLE, 1, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 1, 8'd4, S_IDLE, 1, 0, 0);
        vecs[15] = mk(0, 1, 0, 0, 1, 8'd4, S_ON,   1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].busy, vecs[i].wake, vecs[i].frc, vecs[i].ack, vecs[i].thr);
            tick();
            expect_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].en, vecs[i].req, vecs[i].gated);
        end

        // Busy blips never let the idle count reach the threshold.
        drive(1, 0, 0, 0, 0, 8'd4);
        tick();
        for (int i = 0; i < 30; i++) begin
            drive(0, (i % 3) == 2, 0, 0, 0, 8'd4);
            tick();
            chk("blip.en", 32'(en), 32'd1);
            chk("blip.req", 32'(req), 32'd0);
            chk("blip.state_le_idle", 32'(st <= S_IDLE), 32'd1);
        end

        // Threshold 0 disables gating; force_on inhibits it.
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, 0, 0, 0, 8'd0);
            tick();
            chk("thr0.req", 32'(req), 32'd0);
            chk("thr0.en", 32'(en), 32'd1);
        end
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, 0, 1, 0, 8'd1);
            tick();
            chk("force.req", 32'(req), 32'd0);
            chk("force.en", 32'(en), 32'd1);
        end
        drive(0, 0, 0, 0, 0, 8'd1);
        tick();
        expect_out("thr1.idle", S_IDLE, 1, 0, 0);
        tick();
        expect_out("thr1.req", S_REQ, 1, 1, 0);

        // Lowering the threshold below the count still requests sleep.
        drive(1, 0, 0, 0, 0, 8'd8);
        tick();
        drive(0, 0, 0, 0, 0, 8'd8);
        repeat (5) tick();
        expect_out("thrdrop.idle", S_IDLE, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 8'd3);
        tick();
        expect_out("thrdrop.req", S_REQ, 1, 1, 0);

        // Threshold cleared while idle returns to ON.
        drive(1, 0, 0, 0, 0, 8'd8);
        tick();
        drive(0, 0, 0, 0, 0, 8'd8);
        repeat (2) tick();
        drive(0, 0, 0, 0, 0, 8'd0);
        tick();
        expect_out("thrzero", S_ON, 1, 0, 0);

        // Abort in REQ before any ack.
        reach_req("abort");
        drive(0, 0, 1, 0, 0, 8'd4);
        tick();
        expect_out("abort.w1", S_WAKE, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 8'd4);
        tick();
        expect_out("abort.w2", S_WAKE, 1, 1, 0);
        tick();
        expect_out("abort.w3", S_WAKE, 1, 0, 0);
        tick();
        expect_out("abort.on", S_ON, 1, 0, 0);

        // Wake and ack in the same cycle: wake wins.
        reach_req("tie");
        drive(0, 0, 1, 0, 1, 8'd4);
        tick();
        expect_out("tie.wake", S_WAKE, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 8'd4);
        repeat (3) tick();
        expect_out("tie.on", S_ON, 1, 0, 0);

        // Wake from OFF with ack held, gated clock silent while OFF.
        reach_req("woff");
        drive(0, 0, 0, 0, 1, 8'd4);
        tick();
        expect_out("woff.off", S_OFF, 0, 1, 1);
        tick();
        g0 = gclk_cnt;
        repeat (5) tick();
        chk("woff.gclk_stopped", 32'(gclk_cnt - g0), 32'd0);
        drive(0, 0, 1, 0, 1, 8'd4);
        tick();
        expect_out("woff.w1", S_WAKE, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 8'd4);
        tick();
        expect_out("woff.w2", S_WAKE, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out("woff.ackheld", S_WAKE, 1, 0, 0);
        end
        drive(0, 0, 0, 0, 0, 8'd0);
        tick();
        expect_out("woff.on", S_ON, 1, 0, 0);
        g0 = gclk_cnt;
        repeat (5) tick();
        chk("on.gclk_running", 32'(gclk_cnt - g0), 32'd5);

        // Reset while gated.
        reach_req("rstoff");
`ifdef CLK_GATE_CTRL_STAT_EN
        g0 = evt_cnt;
`endif
        drive(0, 0, 0, 0, 1, 8'd4);
        tick();
        expect_out("rstoff.off", S_OFF, 0, 1, 1);
        repeat (10) tick();
`ifdef CLK_GATE_CTRL_STAT_EN
        chk("stat.gate_cnt", gate_cnt, 32'd10);
        chk("stat.evt_pulses", 32'(evt_cnt - g0), 32'd1);
`endif
        drive(1, 0, 0, 0, 1, 8'd4);
        tick();
        expect_out("rstoff.on", S_ON, 1, 0, 0);
`ifdef CLK_GATE_CTRL_STAT_EN
        chk("stat.cnt_cleared", gate_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
